// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT over a dual-port sample RAM.
// Optional abort support is compiled in with `define FFT_SEQ_ABORT_EN.
module fft_stage_sequencer #(
   parameter int N_LOG2     = 8,
   parameter int BF_LATENCY = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              fft_start,
`ifdef FFT_SEQ_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   output logic              mem_sel,
   output logic              busy,
   output logic              done,
   output logic [N_LOG2-1:0] stage,
   output logic              rd_en,
   output logic [N_LOG2-1:0] rd_addr_a,
   output logic [N_LOG2-1:0] rd_addr_b,
   output logic [N_LOG2-2:0] tw_addr,
   output logic              bf_valid,
   output logic              wr_en,
   output logic [N_LOG2-1:0] wr_addr_a,
   output logic [N_LOG2-1:0] wr_addr_b
);

   localparam int W = N_LOG2;
   localparam int L = 1 + BF_LATENCY;
   localparam logic [W-1:0] LAST_STAGE = W'(W - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t       state, state_nxt;
   logic [W-2:0] j, j_nxt;
   logic [W-1:0] stage_q, stage_nxt;
   logic         issue;
   logic         stop_now;
   logic         kill;
   logic         finish_abort;
   logic         drain_empty;

   logic [L:1]   vld_pipe;
   logic [W-1:0] pipe_a [1:L];
   logic [W-1:0] pipe_b [1:L];

   logic [W-1:0] jw, half, k, g, addr_a, tw_shift;

`ifdef FFT_SEQ_ABORT_EN
   logic abort_pend;
   assign stop_now = abort;
   assign kill     = abort_pend | abort;
`else
   assign stop_now = 1'b0;
   assign kill     = 1'b0;
`endif

   // Only the final pipeline slot may be occupied when the barrier releases:
   // that slot is the stage's last write-back, emitted this very cycle.
   assign drain_empty = (vld_pipe[L-1:1] == '0);

   always_comb begin
      state_nxt    = state;
      j_nxt        = j;
      stage_nxt    = stage_q;
      issue        = 1'b0;
      finish_abort = 1'b0;
      case (state)
         IDLE: begin
            if (fft_start) begin
               state_nxt = ISSUE;
               j_nxt     = '0;
               stage_nxt = '0;
            end
         end
         ISSUE: begin
            if (stop_now) begin
               state_nxt = DRAIN;
            end else begin
               issue = 1'b1;
               j_nxt = j + 1'b1;
               if (j == '1) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_empty) begin
               if (kill) begin
                  state_nxt    = IDLE;
                  finish_abort = 1'b1;
               end else if (stage_q == LAST_STAGE) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ISSUE;
                  stage_nxt = stage_q + 1'b1;
                  j_nxt     = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Butterfly j of the stage splits into group g and offset k within the group.
   always_comb begin
      jw       = {1'b0, j};
      half     = W'(1) << stage_q;
      k        = jw & (half - W'(1));
      g        = jw >> stage_q;
      addr_a   = (g << (stage_q + 1'b1)) | k;
      tw_shift = LAST_STAGE - stage_q;
   end

   assign rd_en     = issue;
   assign rd_addr_a = issue ? addr_a : '0;
   assign rd_addr_b = issue ? (addr_a + half) : '0;
   assign tw_addr   = issue ? (k[W-2:0] << tw_shift) : '0;
   assign mem_sel   = (state != IDLE);
   assign busy      = (state == ISSUE) || (state == DRAIN);
   assign done      = (state == DONE);
   assign stage     = stage_q;
   assign bf_valid  = vld_pipe[1];
   assign wr_en     = vld_pipe[L];
   assign wr_addr_a = pipe_a[L];
   assign wr_addr_b = pipe_b[L];

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= IDLE;
         j        <= '0;
         stage_q  <= '0;
         vld_pipe <= '0;
         for (int i = 1; i <= L; i++) begin
            pipe_a[i] <= '0;
            pipe_b[i] <= '0;
         end
      end else begin
         state    <= state_nxt;
         j        <= j_nxt;
         stage_q  <= stage_nxt;
         vld_pipe <= {vld_pipe[L-1:1], rd_en};
         pipe_a[1] <= rd_addr_a;
         pipe_b[1] <= rd_addr_b;
         for (int i = 2; i <= L; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end
      end
   end

`ifdef FFT_SEQ_ABORT_EN
   // An abort seen in ISSUE or DRAIN sticks until the run falls back to IDLE.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         abort_pend <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         abort_pend <= (state_nxt != IDLE) &&
                       (abort_pend || (abort && ((state == ISSUE) || (state == DRAIN))));
         aborted    <= finish_abort;
      end
   end
`else
   logic unused_finish;
   assign unused_finish = finish_abort;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: a small instance (N=8, latency 2) for address patterns and a default instance for timing.
module tb_fft_stage_sequencer;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic start_b = 1'b0, start_s = 1'b0;
   always #5 clk = ~clk;

   logic       mem_sel_b, busy_b, done_b, rd_en_b, bf_valid_b, wr_en_b;
   logic [7:0] stage_b, rd_a_b, rd_b_b, wr_a_b, wr_b_b;
   logic [6:0] tw_b;
   logic       mem_sel_s, busy_s, done_s, rd_en_s, bf_valid_s, wr_en_s;
   logic [2:0] stage_s, rd_a_s, rd_b_s, wr_a_s, wr_b_s;
   logic [1:0] tw_s;
`ifdef FFT_SEQ_ABORT_EN
   logic abort_b = 1'b0, abort_s = 1'b0;
   logic aborted_b, aborted_s;
`endif

   fft_stage_sequencer u_big (
      .clk(clk), .n_rst(n_rst), .fft_start(start_b),
`ifdef FFT_SEQ_ABORT_EN
      .abort(abort_b), .aborted(aborted_b),
`endif
      .mem_sel(mem_sel_b), .busy(busy_b), .done(done_b), .stage(stage_b),
      .rd_en(rd_en_b), .rd_addr_a(rd_a_b), .rd_addr_b(rd_b_b), .tw_addr(tw_b),
      .bf_valid(bf_valid_b), .wr_en(wr_en_b), .wr_addr_a(wr_a_b), .wr_addr_b(wr_b_b)
   );

   fft_stage_sequencer #(.N_LOG2(3), .BF_LATENCY(2)) u_small (
      .clk(clk), .n_rst(n_rst), .fft_start(start_s),
`ifdef FFT_SEQ_ABORT_EN
      .abort(abort_s), .aborted(aborted_s),
`endif
      .mem_sel(mem_sel_s), .busy(busy_s), .done(done_s), .stage(stage_s),
      .rd_en(rd_en_s), .rd_addr_a(rd_a_s), .rd_addr_b(rd_b_s), .tw_addr(tw_s),
      .bf_valid(bf_valid_s), .wr_en(wr_en_s), .wr_addr_a(wr_a_s), .wr_addr_b(wr_b_s)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bad(input string name, input longint act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event at cycle %0d", name, act);
   endtask

   int ec = 0;
   always @(posedge clk) ec <= ec + 1;
   int e0_s = 0, e0_b = 0;

   typedef struct {int cyc; int a; int b; int tw; int stg;} ev_t;
   ev_t rd_q[$], wr_q[$];
   int  done_s_q[$], done_b_q[$], wrc_b_q[$], abt_q[$];

   int mode_b = 0;
   int first_busy, last_busy, busy_cnt, wr_cnt;
   int first_rd[8], last_wr[8];
   int hist_a[0:1199], hist_b[0:1199];
   logic prev_rd_b = 1'b0, prev_rd_s = 1'b0;

   // small-instance monitor
   always @(negedge clk) begin
      int c;
      ev_t e;
      c = ec - e0_s + 1;
      if (bf_valid_s !== prev_rd_s) bad("s_bf_valid_lag", c);
      prev_rd_s = rd_en_s;
      if (rd_en_s) begin
         if (rd_q.size() == 0) bad("s_rd_extra", c);
         else begin
            e = rd_q.pop_front();
            chk("s_rd_cyc", c, e.cyc);
            chk("s_rd_a", rd_a_s, e.a);
            chk("s_rd_b", rd_b_s, e.b);
            chk("s_tw", tw_s, e.tw);
            chk("s_stage", stage_s, e.stg);
            chk("s_busy", busy_s, 1);
         end
      end
      if (wr_en_s) begin
         if (wr_q.size() == 0) bad("s_wr_extra", c);
         else begin
            e = wr_q.pop_front();
            chk("s_wr_cyc", c, e.cyc);
            chk("s_wr_a", wr_a_s, e.a);
            chk("s_wr_b", wr_b_s, e.b);
         end
      end
      if (done_s) begin
         if (done_s_q.size() == 0) bad("s_done_extra", c);
         else begin
            chk("s_done_cyc", c, done_s_q.pop_front());
            chk("s_mem_sel_done", mem_sel_s, 1);
         end
      end
   end

   // default-instance monitor
   always @(negedge clk) begin
      int c;
      c = ec - e0_b + 1;
      if (mode_b == 1) begin
         chk("b_bf_valid_lag", bf_valid_b, prev_rd_b);
         if (busy_b) begin
            if (first_busy < 0) first_busy = c;
            last_busy = c;
            busy_cnt++;
         end
         if (rd_en_b && c < 1200) begin
            hist_a[c] = rd_a_b;
            hist_b[c] = rd_b_b;
            if (first_rd[stage_b[2:0]] < 0) first_rd[stage_b[2:0]] = c;
            if (stage_b == 0) chk("b_tw_stage0", tw_b, 0);
            if (stage_b == 7) chk("b_tw_stage7", tw_b, rd_a_b);
         end
         if (wr_en_b) begin
            wr_cnt++;
            last_wr[stage_b[2:0]] = c;
            if (c >= 6 && c < 1200) begin
               chk("b_wr_a_delay", wr_a_b, hist_a[c-5]);
               chk("b_wr_b_delay", wr_b_b, hist_b[c-5]);
            end else bad("b_wr_early", c);
         end
         if (done_b) begin
            if (done_b_q.size() == 0) bad("b_done_extra", c);
            else begin
               chk("b_done_cyc", c, done_b_q.pop_front());
               chk("b_mem_sel_done", mem_sel_b, 1);
            end
         end
      end else if (mode_b == 2) begin
         if (wr_en_b) begin
            if (wrc_b_q.size() == 0) bad("b_abort_wr_extra", c);
            else chk("b_abort_wr_cyc", c, wrc_b_q.pop_front());
         end
`ifdef FFT_SEQ_ABORT_EN
         if (aborted_b) begin
            if (abt_q.size() == 0) bad("b_aborted_extra", c);
            else chk("b_aborted_cyc", c, abt_q.pop_front());
         end
`endif
         if (done_b) bad("b_abort_done", c);
      end
      prev_rd_b = rd_en_b;
   end

   task automatic wait_cyc_b(input int c);
      while (ec - e0_b + 1 < c) @(negedge clk);
   endtask

   task automatic start_big();
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1 e0_b = ec;
      start_b = 1'b0;
   endtask

   task automatic chk_big_zero(input string tag);
      chk({tag, "_mem_sel"}, mem_sel_b, 0);
      chk({tag, "_busy"}, busy_b, 0);
      chk({tag, "_done"}, done_b, 0);
      chk({tag, "_stage"}, stage_b, 0);
      chk({tag, "_rd_en"}, rd_en_b, 0);
      chk({tag, "_rd_a"}, rd_a_b, 0);
      chk({tag, "_rd_b"}, rd_b_b, 0);
      chk({tag, "_tw"}, tw_b, 0);
      chk({tag, "_bf_valid"}, bf_valid_b, 0);
      chk({tag, "_wr_en"}, wr_en_b, 0);
      chk({tag, "_wr_a"}, wr_a_b, 0);
      chk({tag, "_wr_b"}, wr_b_b, 0);
   endtask

   int pa[12]  = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   int pb[12]  = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   int ptw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

   initial begin
      // reset held with start high: nothing may issue
      n_rst = 1'b0; start_b = 1'b1; start_s = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_big_zero("rst");
      chk("rst_small_rd_en", rd_en_s, 0);
      chk("rst_small_mem_sel", mem_sel_s, 0);
      start_b = 1'b0; start_s = 1'b0;
      n_rst = 1'b1;
      @(negedge clk);

      // small instance: two back-to-back runs with fft_start held high
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++) begin
               rd_q.push_back('{r*23 + 1 + s*7 + i, pa[s*4+i], pb[s*4+i], ptw[s*4+i], s});
               wr_q.push_back('{r*23 + 4 + s*7 + i, pa[s*4+i], pb[s*4+i], 0, s});
            end
      done_s_q.push_back(22);
      done_s_q.push_back(45);
      start_s = 1'b1;
      @(posedge clk);
      #1 e0_s = ec;
      while (ec - e0_s + 1 < 30) @(negedge clk);
      start_s = 1'b0;
      while (ec - e0_s + 1 < 50) @(negedge clk);
      chk("s_rd_q_empty", rd_q.size(), 0);
      chk("s_wr_q_empty", wr_q.size(), 0);
      chk("s_done_q_empty", done_s_q.size(), 0);

      // default instance: full run with an ignored start at cycle 500
      first_busy = -1; last_busy = -1; busy_cnt = 0; wr_cnt = 0;
      for (int s = 0; s < 8; s++) begin first_rd[s] = -1; last_wr[s] = -1; end
      done_b_q.push_back(1065);
      start_big();
      mode_b = 1;
      wait_cyc_b(500);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_cyc_b(1066);
      chk("b_mem_sel_after", mem_sel_b, 0);
      chk("b_busy_after", busy_b, 0);
      wait_cyc_b(1070);
      mode_b = 0;
      chk("b_done_q_empty", done_b_q.size(), 0);
      chk("b_first_busy", first_busy, 1);
      chk("b_last_busy", last_busy, 1064);
      chk("b_busy_cnt", busy_cnt, 1064);
      chk("b_wr_cnt", wr_cnt, 1024);
      for (int s = 0; s < 8; s++) begin
         chk($sformatf("b_first_rd_s%0d", s), first_rd[s], 1 + 133*s);
         chk($sformatf("b_last_wr_s%0d", s), last_wr[s], 133 + 133*s);
         if (s < 7) chk($sformatf("b_barrier_s%0d", s), first_rd[s+1] - last_wr[s], 1);
      end

      // reset in the middle of stage 2
      start_big();
      wait_cyc_b(300);
      n_rst = 1'b0;
      @(negedge clk);
      chk_big_zero("midrst");
      n_rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("midrst_wr_en", wr_en_b, 0);
         chk("midrst_mem_sel", mem_sel_b, 0);
      end

`ifdef FFT_SEQ_ABORT_EN
      // abort during cycle 10 of stage 0
      for (int c = 6; c <= 14; c++) wrc_b_q.push_back(c);
      abt_q.push_back(15);
      start_big();
      mode_b = 2;
      wait_cyc_b(9);
      @(posedge clk);
      #1 abort_b = 1'b1;
      @(negedge clk);
      chk("abort_rd_en_low", rd_en_b, 0);
      chk("abort_busy", busy_b, 1);
      @(posedge clk);
      #1 abort_b = 1'b0;
      wait_cyc_b(30);
      mode_b = 0;
      chk("abort_wr_q_empty", wrc_b_q.size(), 0);
      chk("abort_aborted_q_empty", abt_q.size(), 0);
      chk("abort_mem_sel", mem_sel_b, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequences an in-place radix-2 decimation-in-time FFT over the sample memory loaded by the Avalon slave interface. On `fft_start` it takes ownership of the memory, then issues butterfly read and write address pairs and twiddle addresses stage by stage. It enforces a drain barrier between stages and signals `done` when the transform is complete. The block sits between the Avalon slave (load/start) and the butterfly datapath plus dual-port sample RAM.

## Interface
Parameters:
- `N_LOG2`, 8: log2 of FFT size N; N = 256 by default.
- `BF_LATENCY`, 4: butterfly pipeline depth in cycles, from `bf_valid` to result valid. Must be ≥ 1.

Ports:
- `clk`  in  1: sole clock; all logic is rising-edge.
- `n_rst`  in  1: reset, synchronous, active-low.
- `fft_start`  in  1: start request; sampled only in IDLE.
- `mem_sel`  out  1: memory owner; 0 = Avalon slave, 1 = sequencer.
- `busy`  out  1: high in ISSUE and DRAIN.
- `done`  out  1: one-cycle pulse at completion.
- `stage`  out  N_LOG2 bits: current stage index, 0..N_LOG2-1.
- `rd_en`  out  1: read strobe for the address pair.
- `rd_addr_a`, `rd_addr_b`  out  N_LOG2 each: butterfly top and bottom read addresses.
- `tw_addr`  out  N_LOG2-1: twiddle ROM address, aligned with `rd_en`.
- `bf_valid`  out  1: `rd_en` delayed 1 cycle (RAM read latency); butterfly input valid.
- `wr_en`  out  1: write-back strobe.
- `wr_addr_a`, `wr_addr_b`  out  N_LOG2 each: write-back addresses.

## Operation
States are IDLE, ISSUE, DRAIN and DONE.

- **IDLE**
  - `mem_sel` = 0.
  - `fft_start` = 1 → go to ISSUE; stage = 0, butterfly index j = 0.
- **ISSUE** (one butterfly per cycle)
  - Assert `rd_en`.
  - Let half = 2^stage, k = j & (half−1), g = j >> stage.
  - `rd_addr_a` = g·2·half + k; `rd_addr_b` = `rd_addr_a` + half.
  - `tw_addr` = k << (N_LOG2−1−stage).
  - j increments each cycle. At j = N/2−1, go to DRAIN.
- **DRAIN**
  - `rd_en` = 0.
  - Stay until the stage's last `wr_en` has been emitted (in-flight count reaches 0).
  - Next cycle: if stage < N_LOG2−1, increment stage, clear j, go to ISSUE. Otherwise go to DONE.
- **DONE**
  - `done` = 1 for one cycle, then go to IDLE.
- **Pipeline**
  - `rd_addr_a`/`rd_addr_b` pass through a shift pipeline of length 1+BF_LATENCY and emerge as `wr_addr_a`/`wr_addr_b`.
  - `wr_en` = `rd_en` delayed 1+BF_LATENCY.
- **Assumptions and ownership**
  - Input is assumed bit-reversed in memory; this block does no reordering.
  - `mem_sel` = 1 from the first ISSUE cycle through the DONE cycle inclusive.
- **Boundary rules**
  - `fft_start` while not in IDLE is ignored and does not queue.
  - `fft_start` held high continuously starts a new FFT the cycle after DONE returns to IDLE.
  - Reset mid-operation: next edge → IDLE. The `wr_en` pipeline is cleared and all outputs are at reset values; no partial write is issued after reset.
- **Reset values**
  - All outputs 0: `mem_sel`, `busy`, `done`, `stage`, `rd_en`, all addresses, `bf_valid`, `wr_en`.

## Timing
Let `fft_start` be sampled high in IDLE at edge 0. Let P = N/2 + BF_LATENCY + 1.

- First `rd_en` is in cycle 1.
- Stage s occupies cycles 1 + s·P through s·P + P: N/2 read cycles, then BF_LATENCY+1 drain cycles.
- Last write of stage s occurs in its final cycle.
- First read of stage s+1 is in the following cycle, so there is no read-after-write overlap.
- `busy` is high in cycles 1 .. N_LOG2·P.
- `done` is high in cycle N_LOG2·P + 1.
- Defaults: P = 133; `busy` spans cycles 1..1064; `done` is in cycle 1065; the next start is sampled at edge 1066 at the earliest.
- `bf_valid` lags `rd_en` by exactly 1 cycle.
- `wr_en` lags `rd_en` by exactly 1+BF_LATENCY cycles.

## Configuration
- Macro: `FFT_SEQ_ABORT_EN`.
- Defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - `abort` high in ISSUE: stop issuing immediately and go to DRAIN; already-issued butterflies still write back.
  - After drain, go to IDLE (skip DONE, no `done` pulse) and pulse `aborted` for 1 cycle.
  - `abort` in IDLE or DONE is ignored.
  - `abort` in DRAIN marks the run aborted: no further stage and no `done` pulse.
- Undefined: neither port exists, and every run completes all stages.

## Test plan
- **Reset:** hold `n_rst` = 0 for 2 edges → all outputs 0, state IDLE; assert `fft_start` with `n_rst` = 0 → no `rd_en`.
- **Address pattern (N_LOG2 = 3, BF_LATENCY = 2):**
  - Stage 0 pairs: (0,1) (2,3) (4,5) (6,7), `tw_addr` all 0.
  - Stage 1 pairs: (0,2) (1,3) (4,6) (5,7), `tw_addr` 0,2,0,2.
  - Stage 2 pairs: (0,4) (1,5) (2,6) (3,7), `tw_addr` 0,1,2,3.
- **Full-run timing (defaults):** start at edge 0 → `busy` in cycles 1..1064, `done` only in cycle 1065, 1024 `wr_en` cycles total; each `wr_addr` equals the `rd_addr` from 5 cycles earlier.
- **Stage barrier:** in every stage, the last `wr_en` cycle < the next stage's first `rd_en` cycle, with a gap of exactly 1 edge.
- **Ignored start / reset mid-run:**
  - `fft_start` pulsed at cycle 500 → no effect, `done` still in cycle 1065.
  - `n_rst` = 0 at cycle 300 → IDLE next edge, `wr_en` = 0 thereafter, `mem_sel` = 0.
- **Abort (with `FFT_SEQ_ABORT_EN`):** `abort` at cycle 10 → `rd_en` low from cycle 10, exactly 9 `wr_en` pulses total (cycles 6..14), `aborted` in cycle 15, never `done`.
